tv80_alu16_seq: RTL and testbench

- Two-pass sequencer that drives the shared 8-bit TV80 ALU to execute 16-bit ADD/ADC/SBC on register pairs.
- Pass 1 runs the low byte and pass 2 runs the high byte, chaining carry/borrow and the Z flag through the ALU's own flag path.
- It sits between the instruction decoder and the ALU.
- Valid/ready request and response handshakes isolate it from decoder timing.

---
 rtl/tv80_alu16_seq.sv | 135 +++++++++++++
 tb/tb_tv80_alu16_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tv80_alu16_seq.sv
// rtl/tv80_alu16_seq.sv - two-pass 16-bit ADD/ADC/SBC sequencer driving the shared 8-bit TV80 ALU
module tv80_alu16_seq #(
  parameter int Flag_C = 0,
  parameter int Flag_H = 4,
  parameter int Flag_Z = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [7:0]  req_f,
  output logic [3:0]  alu_op,
  output logic        alu_arith16,
  output logic        alu_z16,
  output logic [7:0]  alu_busa,
  output logic [7:0]  alu_busb,
  output logic [7:0]  alu_f_in,
  input  logic [7:0]  alu_q,
  input  logic [7:0]  alu_f_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_q,
  output logic [7:0]  rsp_f
);

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SBC = 2'b10;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ADC  = 4'b0001;
  localparam logic [3:0] ALU_SBC  = 4'b0011;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  // Flags the high pass actually consumes from the low pass; S/P/X/Y/N are
  // either overwritten by the ALU or, for ADD16, must equal the request F.
  localparam logic [7:0] CHAIN_MASK = 8'((1 << Flag_C) | (1 << Flag_H) | (1 << Flag_Z));

  state_t      state;
  logic [1:0]  op_r;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [7:0]  f_r;
  logic [7:0]  q_lo;
  logic [7:0]  f_mid;

  logic is_adc;
  logic is_sbc;
  logic is_add;

  assign is_adc = (op_r == OP_ADC);
  assign is_sbc = (op_r == OP_SBC);
  assign is_add = !is_adc && !is_sbc;

  assign req_ready = (state == IDLE) && !reset;

  always_comb begin
    alu_op      = ALU_PASS;
    alu_arith16 = 1'b0;
    alu_z16     = 1'b0;
    alu_busa    = 8'h00;
    alu_busb    = 8'h00;
    alu_f_in    = 8'h00;
    case (state)
      LO: begin
        alu_op      = is_sbc ? ALU_SBC : (is_adc ? ALU_ADC : ALU_ADD);
        alu_arith16 = is_add;
        alu_busa    = a_r[7:0];
        alu_busb    = b_r[7:0];
        alu_f_in    = f_r;
      end
      HI: begin
        // Z16 lets an all-zero high byte inherit the low-pass Z.
        alu_op      = is_sbc ? ALU_SBC : ALU_ADC;
        alu_arith16 = is_add;
        alu_z16     = !is_add;
        alu_busa    = a_r[15:8];
        alu_busb    = b_r[15:8];
        alu_f_in    = f_mid;
      end
      default: begin
        alu_op = ALU_PASS;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_r      <= 2'b00;
      a_r       <= 16'h0000;
      b_r       <= 16'h0000;
      f_r       <= 8'h00;
      q_lo      <= 8'h00;
      f_mid     <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_q     <= 16'h0000;
      rsp_f     <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_r  <= req_op;
            a_r   <= req_a;
            b_r   <= req_b;
            f_r   <= req_f;
            state <= LO;
          end
        end
        LO: begin
          q_lo  <= alu_q;
          f_mid <= (alu_f_out & CHAIN_MASK) | (f_r & ~CHAIN_MASK);
          state <= HI;
        end
        HI: begin
          rsp_q     <= {alu_q, q_lo};
          rsp_f     <= alu_f_out;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// tb/tb_tv80_alu16_seq.sv - directed bench for tv80_alu16_seq with a behavioural 8-bit ALU
module tb_tv80_alu16_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [7:0]  req_f;
  logic [3:0]  alu_op;
  logic        alu_arith16;
  logic        alu_z16;
  logic [7:0]  alu_busa;
  logic [7:0]  alu_busb;
  logic [7:0]  alu_f_in;
  logic [7:0]  alu_q;
  logic [7:0]  alu_f_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_q;
  logic [7:0]  rsp_f;

  int    vectors = 0;
  int    miscompares = 0;
  string cur = "reset";

  tv80_alu16_seq dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_f(req_f),
    .alu_op(alu_op), .alu_arith16(alu_arith16), .alu_z16(alu_z16),
    .alu_busa(alu_busa), .alu_busb(alu_busb), .alu_f_in(alu_f_in),
    .alu_q(alu_q), .alu_f_out(alu_f_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_f(rsp_f)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_model(input logic [3:0] op, input logic ar16, input logic z16,
                                            input logic [7:0] a, input logic [7:0] b, input logic [7:0] fin);
    logic [8:0] r;
    logic [4:0] hr;
    logic       cin;
    logic       sub;
    logic [7:0] q;
    logic [7:0] f;
    q = 8'h00;
    f = fin;
    if (op == 4'b0000 || op == 4'b0001 || op == 4'b0011) begin
      sub = (op == 4'b0011);
      cin = (op != 4'b0000) && fin[0];
      if (sub) begin
        r  = {1'b0, a} - {1'b0, b} - {8'b0, cin};
        hr = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, cin};
      end else begin
        r  = {1'b0, a} + {1'b0, b} + {8'b0, cin};
        hr = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
      end
      q    = r[7:0];
      f[7] = q[7];
      f[6] = (q == 8'h00) ? (z16 ? fin[6] : 1'b1) : 1'b0;
      f[5] = q[5];
      f[4] = hr[4];
      f[3] = q[3];
      f[2] = sub ? ((a[7] != b[7]) && (q[7] != a[7])) : ((a[7] == b[7]) && (q[7] != a[7]));
      f[1] = sub;
      f[0] = r[8];
      if (ar16) begin
        f[7] = fin[7];
        f[6] = fin[6];
        f[2] = fin[2];
      end
    end
    return {q, f};
  endfunction

  always_comb {alu_q, alu_f_out} = alu_model(alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_f_in);

  task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s %s: observed %0h expected %0h", cur, name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic [7:0] f);
    logic       add_like;
    logic [3:0] lo_op;
    logic [3:0] hi_op;
    add_like = (op == 2'b00) || (op == 2'b11);
    lo_op    = (op == 2'b10) ? 4'b0011 : ((op == 2'b01) ? 4'b0001 : 4'b0000);
    hi_op    = (op == 2'b10) ? 4'b0011 : 4'b0001;
    for (int i = 0; i < 8 && req_ready !== 1'b1; i++) tick;
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_f = f;
    tick;
    req_valid = 1'b0; req_op = ~op; req_a = ~a; req_b = ~b; req_f = ~f;
    chk("lo_alu_op", alu_op, lo_op);
    chk("lo_busa", alu_busa, a[7:0]);
    chk("lo_busb", alu_busb, b[7:0]);
    chk("lo_f_in", alu_f_in, f);
    chk("lo_arith16", alu_arith16, add_like);
    chk("lo_z16", alu_z16, 1'b0);
    chk("lo_req_ready", req_ready, 1'b0);
    chk("lo_rsp_valid", rsp_valid, 1'b0);
    tick;
    chk("hi_alu_op", alu_op, hi_op);
    chk("hi_busa", alu_busa, a[15:8]);
    chk("hi_busb", alu_busb, b[15:8]);
    chk("hi_arith16", alu_arith16, add_like);
    chk("hi_z16", alu_z16, !add_like);
    chk("hi_rsp_valid", rsp_valid, 1'b0);
    tick;
  endtask

  task automatic expect_rsp(input logic [15:0] q, input logic [7:0] f);
    vectors += 5;
    if (rsp_valid !== 1'b1) begin
      miscompares++;
      $error("FAIL %s rsp_valid: observed %0h expected 1", cur, rsp_valid);
    end
    if (rsp_q !== q) begin
      miscompares++;
      $error("FAIL %s rsp_q: observed %0h expected %0h", cur, rsp_q, q);
    end
    if (rsp_f !== f) begin
      miscompares++;
      $error("FAIL %s rsp_f: observed %0h expected %0h", cur, rsp_f, f);
    end
    if (req_ready !== 1'b0) begin
      miscompares++;
      $error("FAIL %s resp_req_ready: observed %0h expected 0", cur, req_ready);
    end
    if (alu_op !== 4'b1111) begin
      miscompares++;
      $error("FAIL %s resp_alu_op: observed %0h expected f", cur, alu_op);
    end
  endtask

  task automatic consume;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 1'b0);
    chk("post_req_ready", req_ready, 1'b1);
    chk("post_alu_op", alu_op, 4'b1111);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 2'b00; req_a = 16'h0000; req_b = 16'h0000; req_f = 8'h00;
    tick;
    tick;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_q", rsp_q, 16'h0000);
    chk("rst_rsp_f", rsp_f, 8'h00);
    chk("rst_alu_op", alu_op, 4'b1111);
    chk("rst_arith16", alu_arith16, 1'b0);
    chk("rst_z16", alu_z16, 1'b0);
    chk("rst_busa", alu_busa, 8'h00);
    chk("rst_busb", alu_busb, 8'h00);
    chk("rst_f_in", alu_f_in, 8'h00);
    reset = 1'b0;
    #1;
    chk("idle_req_ready", req_ready, 1'b1);

    cur = "add16_0fff_0001";
    issue(2'b00, 16'h0FFF, 16'h0001, 8'hC4);
    expect_rsp(16'h1000, 8'hD4);
    consume();

    cur = "adc16_7fff_0000";
    issue(2'b01, 16'h7FFF, 16'h0000, 8'h01);
    expect_rsp(16'h8000, 8'h94);
    consume();

    cur = "sbc16_0000_0001";
    issue(2'b10, 16'h0000, 16'h0001, 8'h00);
    expect_rsp(16'hFFFF, 8'hBB);
    consume();

    cur = "sbc16_1234_1234";
    issue(2'b10, 16'h1234, 16'h1234, 8'h00);
    expect_rsp(16'h0000, 8'h42);
    consume();

    cur = "rsvd11_0fff_0001";
    issue(2'b11, 16'h0FFF, 16'h0001, 8'hC4);
    expect_rsp(16'h1000, 8'hD4);
    consume();

    cur = "add16_ffff_0001";
    issue(2'b00, 16'hFFFF, 16'h0001, 8'h00);
    expect_rsp(16'h0000, 8'h11);
    consume();

    cur = "adc16_0100_hold";
    issue(2'b01, 16'h0100, 16'h0000, 8'h00);
    for (int i = 0; i < 5; i++) begin
      expect_rsp(16'h0100, 8'h00);
      req_valid = 1'b1; req_op = 2'b00; req_a = 16'hAAAA; req_b = 16'h5555; req_f = 8'hFF;
      tick;
      req_valid = 1'b0;
    end
    expect_rsp(16'h0100, 8'h00);
    consume();
    tick;
    chk("no_ghost_op", alu_op, 4'b1111);
    chk("no_ghost_rsp", rsp_valid, 1'b0);

    cur = "reset_in_hi";
    req_valid = 1'b1; req_op = 2'b01; req_a = 16'h1111; req_b = 16'h2222; req_f = 8'h00;
    tick;
    req_valid = 1'b0;
    tick;
    chk("in_hi_alu_op", alu_op, 4'b0001);
    reset = 1'b1;
    #1;
    chk("rst_hi_req_ready", req_ready, 1'b0);
    tick;
    reset = 1'b0;
    #1;
    chk("after_rst_req_ready", req_ready, 1'b1);
    chk("after_rst_rsp_valid", rsp_valid, 1'b0);
    chk("after_rst_alu_op", alu_op, 4'b1111);
    tick;
    tick;
    tick;
    chk("discarded_rsp_valid", rsp_valid, 1'b0);

    cur = "add16_after_reset";
    issue(2'b00, 16'h0001, 16'h0001, 8'h00);
    expect_rsp(16'h0002, 8'h00);
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
